// File: rtl/iir_coeff_pkg.sv
`default_nettype none
// ============================================================================
// Package : iir_coeff_pkg
// Coefficient indices, commit state and unity-gain helper for the coefficient bank.
// Rev     : 1.0
// ============================================================================
package iir_coeff_pkg;

  localparam int A1_S0_C       = 0;
  localparam int A2_S0_C       = 1;
  localparam int K_S0_C        = 2;
  localparam int A1_S1_C       = 3;
  localparam int A2_S1_C       = 4;
  localparam int K_S1_C        = 5;
  localparam int A1_S2_C       = 6;
  localparam int A2_S2_C       = 7;
  localparam int K_S2_C        = 8;
  localparam int COEFF_COUNT_C = 9;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  function automatic logic [31:0] unity_gain(input int unsigned q);
    return 32'd1 << q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iir_coefficient_bank.sv
`default_nettype none
// ============================================================================
// Module : iir_coefficient_bank
// Shadow/active coefficient bank with in-flight-safe commit for the biquad cascade.
// Rev    : 1.0
// ============================================================================
module iir_coefficient_bank
  import iir_coeff_pkg::*;
#(
  parameter int DATA_WIDTH_P      = 24,
  parameter int NR_OF_Q_BITS_P    = 20,
  parameter int IN_FLIGHT_WIDTH_P = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    x_valid,
  input  logic [DATA_WIDTH_P-1:0] x,
  output logic                    x_valid_out,
  output logic [DATA_WIDTH_P-1:0] x_out,
  input  logic                    y_valid,
  input  logic                    cr_wr_en,
  input  logic [3:0]              cr_wr_addr,
  input  logic [DATA_WIDTH_P-1:0] cr_wr_data,
  input  logic                    cr_commit,
  output logic                    sr_commit_pending,
  output logic                    sr_commit_done,
  output logic                    sr_error,
  output logic [DATA_WIDTH_P-1:0] cr_a1_section_0,
  output logic [DATA_WIDTH_P-1:0] cr_a2_section_0,
  output logic [DATA_WIDTH_P-1:0] cr_gain_k_section_0,
  output logic [DATA_WIDTH_P-1:0] cr_a1_section_1,
  output logic [DATA_WIDTH_P-1:0] cr_a2_section_1,
  output logic [DATA_WIDTH_P-1:0] cr_gain_k_section_1,
  output logic [DATA_WIDTH_P-1:0] cr_a1_section_2,
  output logic [DATA_WIDTH_P-1:0] cr_a2_section_2,
  output logic [DATA_WIDTH_P-1:0] cr_gain_k_section_2
);

  typedef logic [DATA_WIDTH_P-1:0] coeff_t;

  localparam coeff_t c_unity_gain = DATA_WIDTH_P'(unity_gain(NR_OF_Q_BITS_P));

  // Every third entry is a section gain; reset leaves the cascade as pass-through.
  function automatic coeff_t reset_value(input int idx);
    return ((idx % 3) == 2) ? c_unity_gain : '0;
  endfunction

  coeff_t                       shadow_q [COEFF_COUNT_C];
  coeff_t                       shadow_d [COEFF_COUNT_C];
  coeff_t                       active_q [COEFF_COUNT_C];
  coeff_t                       active_d [COEFF_COUNT_C];
  logic [IN_FLIGHT_WIDTH_P-1:0] cnt_q, cnt_d;
  logic                         error_q, error_d;
  logic                         x_valid_out_q, x_valid_out_d;
  coeff_t                       x_out_q, x_out_d;
  logic                         commit_done_q, commit_done_d;
  commit_state_e                state_q, state_d;
  logic                         copy_cond;
  logic                         commit_fire;

  // No sample in the cascade, none in our register, none arriving this cycle.
  assign copy_cond = (cnt_q == '0) && !x_valid_out_q && !x_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cr_commit) state_d = ST_PENDING;
      ST_PENDING: if (copy_cond) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_commit_pending = (state_q == ST_PENDING);
    commit_fire       = (state_q == ST_PENDING) && copy_cond;
  end

  always_comb begin
    cnt_d   = cnt_q;
    error_d = error_q;
    if (x_valid_out_q && !y_valid) begin
      if (&cnt_q) error_d = 1'b1;
      else        cnt_d   = cnt_q + 1'b1;
    end else if (y_valid && !x_valid_out_q) begin
      if (cnt_q == '0) error_d = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // The commit copies the shadow next-state so a same-cycle write is included.
  always_comb begin
    shadow_d = shadow_q;
    if (cr_wr_en && (cr_wr_addr < 4'(COEFF_COUNT_C))) begin
      shadow_d[cr_wr_addr] = cr_wr_data;
    end
    if (commit_fire) active_d = shadow_d;
    else             active_d = active_q;
    x_valid_out_d = x_valid;
    x_out_d       = x_valid ? x : x_out_q;
    commit_done_d = commit_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COEFF_COUNT_C; i++) begin
        shadow_q[i] <= reset_value(i);
        active_q[i] <= reset_value(i);
      end
      cnt_q         <= '0;
      error_q       <= 1'b0;
      x_valid_out_q <= 1'b0;
      x_out_q       <= '0;
      commit_done_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      cnt_q         <= cnt_d;
      error_q       <= error_d;
      x_valid_out_q <= x_valid_out_d;
      x_out_q       <= x_out_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign x_valid_out         = x_valid_out_q;
  assign x_out               = x_out_q;
  assign sr_commit_done      = commit_done_q;
  assign sr_error            = error_q;
  assign cr_a1_section_0     = active_q[A1_S0_C];
  assign cr_a2_section_0     = active_q[A2_S0_C];
  assign cr_gain_k_section_0 = active_q[K_S0_C];
  assign cr_a1_section_1     = active_q[A1_S1_C];
  assign cr_a2_section_1     = active_q[A2_S1_C];
  assign cr_gain_k_section_1 = active_q[K_S1_C];
  assign cr_a1_section_2     = active_q[A1_S2_C];
  assign cr_a2_section_2     = active_q[A2_S2_C];
  assign cr_gain_k_section_2 = active_q[K_S2_C];

endmodule
`default_nettype wire

// File: tb/tb_iir_coefficient_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_iir_coefficient_bank
// Scoreboard bench for iir_coefficient_bank with a behavioural bank model.
// Rev    : 1.0
// ============================================================================
module tb_iir_coefficient_bank;

  typedef logic [8:0][23:0] bank_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic [23:0] x = '0;
  logic        x_valid_out;
  logic [23:0] x_out;
  logic        y_valid = 1'b0;
  logic        cr_wr_en = 1'b0;
  logic [3:0]  cr_wr_addr = '0;
  logic [23:0] cr_wr_data = '0;
  logic        cr_commit = 1'b0;
  logic        sr_commit_pending, sr_commit_done, sr_error;
  logic [23:0] a1_0, a2_0, k_0, a1_1, a2_1, k_1, a1_2, a2_2, k_2;
  bank_t       act;

  assign act = {k_2, a2_2, a1_2, k_1, a2_1, a1_1, k_0, a2_0, a1_0};

  iir_coefficient_bank #(
    .DATA_WIDTH_P      (24),
    .NR_OF_Q_BITS_P    (20),
    .IN_FLIGHT_WIDTH_P (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .x_valid             (x_valid),
    .x                   (x),
    .x_valid_out         (x_valid_out),
    .x_out               (x_out),
    .y_valid             (y_valid),
    .cr_wr_en            (cr_wr_en),
    .cr_wr_addr          (cr_wr_addr),
    .cr_wr_data          (cr_wr_data),
    .cr_commit           (cr_commit),
    .sr_commit_pending   (sr_commit_pending),
    .sr_commit_done      (sr_commit_done),
    .sr_error            (sr_error),
    .cr_a1_section_0     (a1_0),
    .cr_a2_section_0     (a2_0),
    .cr_gain_k_section_0 (k_0),
    .cr_a1_section_1     (a1_1),
    .cr_a2_section_1     (a2_1),
    .cr_gain_k_section_1 (k_1),
    .cr_a1_section_2     (a1_2),
    .cr_a2_section_2     (a2_2),
    .cr_gain_k_section_2 (k_2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: shadow contents, commit request, samples issued minus returned.
  bank_t       m_shadow;
  bank_t       m_active;
  bit          m_pending;
  bit          m_error;
  bit          m_xv_prev;
  int          m_inflight;
  logic [23:0] sample_q [$];
  bank_t       bank_q [$];

  function automatic bank_t reset_bank();
    bank_t b;
    for (int i = 0; i < 9; i++) b[i] = ((i % 3) == 2) ? 24'h100000 : 24'h000000;
    return b;
  endfunction

  task automatic chkw(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%06h expected=0x%06h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b expected=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow   = reset_bank();
    m_pending  = 1'b0;
    m_error    = 1'b0;
    m_xv_prev  = 1'b0;
    m_inflight = 0;
    sample_q.delete();
    bank_q.delete();
  endtask

  function automatic bit copy_now(input bit xv);
    return m_pending && (m_inflight == 0) && !m_xv_prev && !xv;
  endfunction

  // One clock of stimulus; expected responses are queued for the monitor.
  task automatic cycle(input bit xv, input logic [23:0] xd, input bit yv,
                       input bit we, input logic [3:0] wa, input logic [23:0] wd,
                       input bit cm);
    bank_t sh_n;
    bit    cp, pend_n, err_n;
    int    inf_n;
    x_valid = xv; x = xd; y_valid = yv;
    cr_wr_en = we; cr_wr_addr = wa; cr_wr_data = wd; cr_commit = cm;
    sh_n = m_shadow;
    if (we && (wa < 4'd9)) sh_n[wa] = wd;
    cp     = copy_now(xv);
    pend_n = cp ? 1'b0 : (m_pending || cm);
    inf_n  = m_inflight;
    err_n  = m_error;
    if (m_xv_prev && !yv) begin
      if (m_inflight == 15) err_n = 1'b1;
      else                  inf_n = inf_n + 1;
    end else if (yv && !m_xv_prev) begin
      if (m_inflight == 0) err_n = 1'b1;
      else                 inf_n = inf_n - 1;
    end
    @(posedge clk); #1;
    m_shadow   = sh_n;
    m_pending  = pend_n;
    m_inflight = inf_n;
    m_error    = err_n;
    m_xv_prev  = xv;
    if (cp) bank_q.push_back(sh_n);
    if (xv) sample_q.push_back(xd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((m_inflight != 0 || m_xv_prev || m_pending || bank_q.size() != 0) && budget < 100) begin
      cycle(1'b0, 24'h0, m_inflight > 0, 1'b0, 4'h0, 24'h0, 1'b0);
      budget++;
    end
    chk1("drain_timeout", budget < 100, 1'b1);
  endtask

  task automatic do_reset();
    x_valid = 1'b0; y_valid = 1'b0; cr_wr_en = 1'b0; cr_commit = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = reset_bank();
    end else begin
      if (sr_commit_done) begin
        if (bank_q.size() == 0) chk1("unexpected_commit_done", 1'b1, 1'b0);
        else m_active = bank_q.pop_front();
      end
      for (int i = 0; i < 9; i++) chkw($sformatf("active[%0d]", i), act[i], m_active[i]);
      chk1("commit_pending", sr_commit_pending, m_pending);
      chk1("error", sr_error, m_error);
      if (x_valid_out) begin
        if (sample_q.size() == 0) chk1("unexpected_x_valid_out", 1'b1, 1'b0);
        else chkw("x_out", x_out, sample_q.pop_front());
      end
    end
  end

  initial begin
    bit          xv, yv, we, cm;
    logic [3:0]  wa;
    logic [23:0] wd;
    bit          done;

    do_reset();
    chk1("rst_x_valid_out", x_valid_out, 1'b0);
    chkw("rst_x_out", x_out, 24'h0);
    chk1("rst_commit_done", sr_commit_done, 1'b0);
    chkw("rst_k_s0", k_0, 24'h100000);

    // Sample path latency and hold
    cycle(1'b1, 24'h000123, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
    chk1("lat_x_valid_out", x_valid_out, 1'b1);
    chkw("lat_x_out", x_out, 24'h000123);
    cycle(1'b0, 24'h0ABCDE, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
    chkw("hold_x_out", x_out, 24'h000123);
    drain();

    // Commit with idle cascade
    cycle(1'b0, 24'h0, 1'b0, 1'b1, 4'd3, 24'h0F0000, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1);
    chkw("a1_s1_before_copy", a1_1, 24'h0);
    chk1("pending_after_commit", sr_commit_pending, 1'b1);
    idle(1);
    chkw("a1_s1_after_copy", a1_1, 24'h0F0000);
    chk1("done_pulse", sr_commit_done, 1'b1);
    idle(1);
    chk1("done_single", sr_commit_done, 1'b0);

    // Commit held off by samples in flight
    cycle(1'b1, 24'h000011, 1'b0, 1'b1, 4'd0, 24'h011111, 1'b0);
    cycle(1'b1, 24'h000022, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1);
    idle(3);
    chk1("pending_while_inflight", sr_commit_pending, 1'b1);
    chkw("a1_s0_held", a1_0, 24'h0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0);
    chk1("pending_before_gap", sr_commit_pending, 1'b1);
    idle(2);
    chkw("a1_s0_committed", a1_0, 24'h011111);

    // Writes while pending and in the copy cycle
    cycle(1'b1, 24'h000033, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1, 4'd8, 24'h070000, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (copy_now(1'b0)) begin
        cycle(1'b0, 24'h0, 1'b0, 1'b1, 4'd8, 24'h080000, 1'b0);
        done = 1'b1;
      end else begin
        cycle(1'b0, 24'h0, m_inflight > 0, 1'b0, 4'h0, 24'h0, 1'b0);
      end
    end
    chk1("copy_cycle_reached", done, 1'b1);
    idle(1);
    chkw("k_s2_copy_cycle_write", k_2, 24'h080000);

    // Out-of-range address
    cycle(1'b0, 24'h0, 1'b0, 1'b1, 4'd12, 24'h7FFFFF, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1);
    idle(3);
    chk1("bad_addr_no_error", sr_error, 1'b0);
    chkw("bad_addr_k_s2", k_2, 24'h080000);

    // Randomized traffic with idle windows so commits can land
    for (int n = 0; n < 400; n++) begin
      xv = ((n % 40) < 25) && ($urandom_range(0, 1) == 1) && (m_inflight < 10);
      yv = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
      we = ($urandom_range(0, 2) == 0);
      wa = 4'($urandom_range(0, 15));
      wd = 24'($urandom);
      cm = ($urandom_range(0, 15) == 0);
      cycle(xv, 24'($urandom), yv, we, wa, wd, cm);
    end
    drain();

    // Underflow
    cycle(1'b0, 24'h0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0);
    chk1("underflow_error", sr_error, 1'b1);
    idle(3);
    chk1("error_sticky", sr_error, 1'b1);

    // Reset while pending
    cycle(1'b1, 24'h000044, 1'b0, 1'b1, 4'd0, 24'h123456, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1);
    chk1("pending_pre_reset", sr_commit_pending, 1'b1);
    do_reset();
    chk1("pending_post_reset", sr_commit_pending, 1'b0);
    chk1("error_post_reset", sr_error, 1'b0);
    chkw("a1_s0_post_reset", a1_0, 24'h0);
    chkw("k_s2_post_reset", k_2, 24'h100000);
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1);
    idle(3);
    chkw("a1_s0_shadow_reset", a1_0, 24'h0);

    // Overflow
    for (int i = 0; i < 16; i++) cycle(1'b1, 24'(i), 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
    idle(2);
    chk1("overflow_error", sr_error, 1'b1);

    idle(2);
    chk1("samples_all_seen", sample_q.size() == 0, 1'b1);
    chk1("commits_all_seen", bank_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
